// File: rtl/seq_tx.sv
// Serial bit-sequence transmitter: latches a word on start, shifts it out MSB-first,
// then idles GAP cycles and pulses done. Define SEQ_TX_PARITY_EN to append an even-parity bit.
module seq_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
`ifdef SEQ_TX_PARITY_EN
    S_PARITY = 3'd2,
`endif
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [4:0] SEND_LOAD = 5'(WIDTH - 1);
  localparam logic [4:0] GAP_LOAD  = 5'((GAP > 0) ? GAP - 1 : 0);
  localparam bit         HAS_GAP   = (GAP > 0);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [4:0]       cnt, cnt_next;
`ifdef SEQ_TX_PARITY_EN
  logic             par, par_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef SEQ_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
`ifdef SEQ_TX_PARITY_EN
      par   <= par_next;
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
`ifdef SEQ_TX_PARITY_EN
    par_next   = par;
`endif
    tx_bit     = 1'b0;
    tx_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          shreg_next = data;
          cnt_next   = SEND_LOAD;
          state_next = S_SEND;
`ifdef SEQ_TX_PARITY_EN
          par_next   = ^data;
`endif
        end
      end

      S_SEND: begin
        tx_bit     = shreg[WIDTH-1];
        tx_valid   = 1'b1;
        busy       = 1'b1;
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
        if (cnt == 5'd0) begin
`ifdef SEQ_TX_PARITY_EN
          state_next = S_PARITY;
`else
          if (HAS_GAP) begin
            state_next = S_GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = S_DONE;
          end
`endif
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end

`ifdef SEQ_TX_PARITY_EN
      S_PARITY: begin
        tx_bit   = par;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (HAS_GAP) begin
          state_next = S_GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          state_next = S_DONE;
        end
      end
`endif

      S_GAP: begin
        busy = 1'b1;
        if (cnt == 5'd0) state_next = S_DONE;
        else             cnt_next   = cnt - 5'd1;
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      // Unused encodings fall back to IDLE with all outputs low.
      default: begin
        state_next = S_IDLE;
        shreg_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: frame-position reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_seq_tx;

  localparam int W = 8;
  localparam int G = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Cycles from the accepting edge through the done pulse (11 for 8/2 without parity).
  localparam int L = W + PAR + G + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data = '0;
  logic         tx_bit, tx_valid, busy, done;

  logic         start2 = 1'b0;
  logic [3:0]   data2 = '0;
  logic         tx_bit2, tx_valid2, busy2, done2;

  int checks = 0;
  int errors = 0;

  seq_tx #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  seq_tx #(.WIDTH(4), .GAP(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data(data2),
    .tx_bit(tx_bit2), .tx_valid(tx_valid2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pos is the cycle index within the current frame (0 = idle).
  int           pos = 0;
  logic [W-1:0] word = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) pos <= 0;
    else if (pos == 0) begin
      if (start) begin
        pos  <= 1;
        word <= data;
      end
    end else if (pos == L) pos <= 0;
    else pos <= pos + 1;
  end

  // Returns {tx_bit, tx_valid, busy, done} for frame cycle p of word w.
  function automatic logic [3:0] model_out(input int p, input logic [W-1:0] w);
    if (p >= 1 && p <= W)                  return {w[W-p], 3'b110};
    if (PAR == 1 && p == W + 1)            return {^w, 3'b110};
    if (p > W + PAR && p <= W + PAR + G)   return 4'b0010;
    if (p == L)                            return 4'b0001;
    return 4'b0000;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    e = model_out(pos, word);
    check("tx_bit",   {31'd0, tx_bit},   {31'd0, e[3]});
    check("tx_valid", {31'd0, tx_valid}, {31'd0, e[2]});
    check("busy",     {31'd0, busy},     {31'd0, e[1]});
    check("done",     {31'd0, done},     {31'd0, e[0]});
  end

  // Trace of {tx_bit, tx_valid, busy, done} per cycle after an accepting edge.
  logic [3:0] tr [1:16];

  task automatic trace_frame(input logic [W-1:0] d, input int n);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    tr[1] = {tx_bit, tx_valid, busy, done};
    for (int c = 2; c <= n; c++) begin
      @(negedge clk);
      tr[c] = {tx_bit, tx_valid, busy, done};
    end
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    logic [3:0] pat2;
    int         done_at [$];
    int         ones;

    // Reset held with start high: nothing may leave IDLE.
    start = 1'b1;
    data  = 8'hA5;
    repeat (5) begin
      @(negedge clk);
      check("rst_hold_outs", {28'd0, tx_bit, tx_valid, busy, done}, 32'd0);
    end
    start = 1'b0;
    #2 reset = 1'b0;

    // Directed frame 10100101.
    pat = 8'b10100101;
    trace_frame(pat, 13);
    for (int k = 1; k <= 8; k++) begin
      check("d1_bit",   {31'd0, tr[k][3]}, {31'd0, pat[8-k]});
      check("d1_valid", {31'd0, tr[k][2]}, 32'd1);
    end
    check("d1_c9_bit",   {31'd0, tr[9][3]}, 32'd0);
    check("d1_c9_valid", {31'd0, tr[9][2]}, PAR);
    check("d1_c9_busy",  {31'd0, tr[9][1]}, 32'd1);
    check("d1_c10_bit",  {31'd0, tr[10][3]}, 32'd0);
    check("d1_c10_busy", {31'd0, tr[10][1]}, 32'd1);
    check("d1_done",     {31'd0, tr[11 + PAR][0]}, 32'd1);
    check("d1_done_busy",{31'd0, tr[11 + PAR][1]}, 32'd0);
    check("d1_idle",     {28'd0, tr[12 + PAR]}, 32'd0);
    idle_cycles(2);

    // Odd-weight word: parity cycle carries 1 when enabled.
    trace_frame(8'b10100100, 13);
    check("d2_c9_bit",   {31'd0, tr[9][3]}, PAR);
    check("d2_c9_valid", {31'd0, tr[9][2]}, PAR);
    idle_cycles(2);

    // GAP=0, WIDTH=4 instance.
    pat2 = 4'b0110;
    @(negedge clk);
    start2 = 1'b1;
    data2  = pat2;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      data2  = 4'hF;
      if (c <= 4) begin
        check("g0_bit",   {31'd0, tx_bit2}, {31'd0, pat2[4-c]});
        check("g0_valid", {31'd0, tx_valid2}, 32'd1);
      end else if (c == 5 + PAR) begin
        check("g0_done", {31'd0, done2}, 32'd1);
        check("g0_busy", {31'd0, busy2}, 32'd0);
      end else if (c > 5 + PAR) begin
        check("g0_idle", {28'd0, tx_bit2, tx_valid2, busy2, done2}, 32'd0);
      end else begin
        check("g0_parity", {30'd0, tx_bit2, tx_valid2}, 32'd1);
      end
    end

    // Start held high: one frame every L+1 cycles; data changes mid-frame.
    @(negedge clk);
    start = 1'b1;
    data  = 8'hFF;
    ones  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      data = (c < 3) ? 8'hFF : ((c < L) ? W'($urandom) : 8'h00);
      if (c <= L && tx_valid && tx_bit) ones++;
      if (done) done_at.push_back(c);
    end
    start = 1'b0;
    check("b2b_ones", ones, W);
    check("b2b_count", done_at.size(), 3);
    if (done_at.size() >= 2) check("b2b_period", done_at[1] - done_at[0], L + 1);
    idle_cycles(L + 2);

    // Asynchronous reset mid-SEND clears outputs before the next edge.
    trace_frame(8'hFF, 3);
    #2 reset = 1'b1;
    #1 check("async_rst", {28'd0, tx_bit, tx_valid, busy, done}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    idle_cycles(L + 2);
    check("after_abort", {28'd0, tx_bit, tx_valid, busy, done}, 32'd0);

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(3) == 0) || (c >= 1000 && c < 1200);
      data  = W'($urandom);
      if ($urandom_range(400) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
